// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the MMIO UART TX register and the uart core.
// Buffers CPU bytes and hands them off one at a time with a tx_ena pulse gated by tx_busy.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_BITS    = 4,
  parameter int unsigned BUSY_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_BITS:0]    level,
  output logic                  overflow,
  output logic                  idle,
  output logic                  tx_ena,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DepthCnt = (ADDR_BITS + 1)'(Depth);
  localparam logic [ADDR_BITS:0] CntOne = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PtrOne = (ADDR_BITS)'(1);
  localparam logic [7:0] TmoLast = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [ADDR_BITS:0]      count_q, count_d;
  logic [ADDR_BITS-1:0]    wr_ptr_q, rd_ptr_q;
  logic                    overflow_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];
  logic                    push, drop, pop;

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign overflow = overflow_q;
  assign idle     = empty && (state_q == StIdle);
  assign tx_data  = tx_data_q;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never admits a push.
  assign push = wr_en && !full && !clear;
  assign drop = wr_en && full && !clear;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    tx_ena  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy && !clear) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_ena  = 1'b1;
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      // Flushing leaves the FSM alone so a byte already handed off still completes.
      if (clear) begin
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        overflow_q <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
        if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
        if (drop) overflow_q <= 1'b1;
      end
      if (pop) tx_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based model checked every cycle plus
// directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int TO    = 32;

  logic       clk = 1'b0;
  logic       resetn, clear, wr_en, tx_busy;
  logic [7:0] wr_data;
  logic       full, empty, overflow, idle, tx_ena;
  logic [4:0] level;
  logic [7:0] tx_data;

  uart_tx_fifo #(
    .DATA_WIDTH  (8),
    .ADDR_BITS   (4),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow),
    .idle    (idle),
    .tx_ena  (tx_ena),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: byte queue plus a transmitter that is either free, about to
  // pulse, or handed off and waiting for the core to finish (or the timeout).
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  bit         m_valid = 1'b0;
  bit         m_ovf, m_send, m_hold, m_rose, m_pop;
  int         m_timer, m_n;
  logic [7:0] m_data;

  always @(posedge clk) begin
    if (resetn === 1'b0) begin
      mq.delete();
      m_ovf = 0; m_send = 0; m_hold = 0; m_rose = 0; m_timer = 0; m_data = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_n   = mq.size();
      m_pop = !m_send && !m_hold && (m_n > 0) && !tx_busy && !clear;
      if (m_send) begin
        m_send = 0; m_hold = 1; m_rose = 0; m_timer = 0;
      end else if (m_hold) begin
        if (!m_rose) begin
          if (tx_busy) m_rose = 1;
          else if (m_timer == TO - 1) m_hold = 0;
          else m_timer++;
        end else if (!tx_busy) begin
          m_hold = 0;
        end
      end
      if (clear) begin
        mq.delete();
        m_ovf = 0;
      end else begin
        if (m_pop) begin
          m_data = mq.pop_front();
          m_send = 1;
        end
        if (wr_en) begin
          if (m_n < DEPTH) mq.push_back(wr_data);
          else m_ovf = 1;
        end
      end
    end
  end

  logic [17:0] exp_vec, act_vec;
  always @(negedge clk) begin
    if (m_valid) begin
      exp_vec = {5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovf,
                 (mq.size() == 0) && !m_send && !m_hold, m_send, m_data};
      act_vec = {level, full, empty, overflow, idle, tx_ena, tx_data};
      chk("cycle_model", 32'(act_vec), 32'(exp_vec));
      if (tx_ena === 1'b1) sent.push_back(tx_data);
    end
  end

  // UART core stand-in: 0 = busy for 10 cycles after each tx_ena, 1 = stuck high, 2 = stuck low.
  int busy_mode = 0;
  int busy_cnt  = 0;
  always @(negedge clk) begin
    if (busy_mode == 1) begin
      tx_busy = 1'b1;
    end else if (busy_mode == 2) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (tx_ena === 1'b1) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000 && idle !== 1'b1; i++) step();
    chk(name, 32'(idle), 1);
  endtask

  int first_c, second_c;

  initial begin
    resetn = 1'b0; clear = 1'b0; wr_en = 1'b1; wr_data = 8'h5A; tx_busy = 1'b0;
    // Reset held 3 cycles with writes requested
    repeat (3) step();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_tx_ena", 32'(tx_ena), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    resetn = 1'b1; wr_en = 1'b0;
    step(); step();

    // Single byte latency
    sent.delete();
    push(8'h41);
    chk("t2_empty_c1", 32'(empty), 0);
    chk("t2_ena_c1", 32'(tx_ena), 0);
    step();
    chk("t2_ena_c2", 32'(tx_ena), 1);
    chk("t2_data_c2", 32'(tx_data), 32'h41);
    step();
    chk("t2_ena_c3", 32'(tx_ena), 0);
    repeat (9) step();
    chk("t2_idle_c12", 32'(idle), 0);
    step();
    chk("t2_idle_c13", 32'(idle), 1);
    chk("t2_sent_n", 32'(sent.size()), 1);

    // Fill past capacity while the core is busy
    sent.delete();
    busy_mode = 1;
    step();
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) begin
        chk("t3_full16", 32'(full), 1);
        chk("t3_level16", 32'(level), 16);
        chk("t3_ovf16", 32'(overflow), 0);
      end
    end
    chk("t3_ovf17", 32'(overflow), 1);
    chk("t3_level17", 32'(level), 16);
    busy_mode = 0;
    wait_idle("t3_drain");
    chk("t3_sent_n", 32'(sent.size()), 16);
    for (int i = 0; i < 16; i++)
      chk("t3_order", 32'(i < sent.size() ? sent[i] : 8'hxx), 32'(i));

    // Full FIFO, push in the same cycle as a pop
    clear = 1'b1; step(); clear = 1'b0;
    sent.delete();
    busy_mode = 1;
    step();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    chk("t4_full", 32'(full), 1);
    chk("t4_ovf_pre", 32'(overflow), 0);
    busy_mode = 0;
    push(8'hAA);
    chk("t4_level15", 32'(level), 15);
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_ena", 32'(tx_ena), 1);
    chk("t4_data", 32'(tx_data), 32'h20);
    wait_idle("t4_drain");
    chk("t4_sent_n", 32'(sent.size()), 16);
    for (int i = 0; i < 16; i++)
      chk("t4_order", 32'(i < sent.size() ? sent[i] : 8'hxx), 32'h20 + 32'(i));

    // Clear while the first of five bytes is in flight
    sent.delete();
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("t5_level", 32'(level), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_busy_frame", 32'(idle), 0);
    wait_idle("t5_drain");
    repeat (20) step();
    chk("t5_sent_n", 32'(sent.size()), 1);
    chk("t5_sent0", 32'(sent.size() > 0 ? sent[0] : 8'hxx), 32'h50);

    // Busy never rises: timeout then next byte
    sent.delete();
    busy_mode = 2;
    step();
    push(8'h61);
    push(8'h62);
    first_c = -1; second_c = -1;
    for (int c = 2; c < 46; c++) begin
      if (tx_ena === 1'b1) begin
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
      end
      step();
    end
    chk("t6_first_ena", 32'(first_c), 2);
    chk("t6_second_ena", 32'(second_c), 2 + TO + 2);
    wait_idle("t6_timeout_idle");
    chk("t6_sent_n", 32'(sent.size()), 2);
    chk("t6_sent1", 32'(sent.size() > 1 ? sent[1] : 8'hxx), 32'h62);

    // Reset during the wait-for-done phase
    busy_mode = 0;
    step();
    sent.delete();
    push(8'h71); push(8'h72); push(8'h73);
    step(); step();
    chk("t6_level_pre", 32'(level), 2);
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("t6_rst_ena", 32'(tx_ena), 0);
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_idle", 32'(idle), 1);
    repeat (15) step();
    chk("t6_rst_sent_n", 32'(sent.size()), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
